// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory port: access sizes, FSM states, segment bases.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] TEXT_BASE = 32'h00400000;
    localparam logic [31:0] DATA_BASE = 32'h10010000;
    localparam logic [31:0] STACK_TOP = 32'h7fffeffc;

endpackage

// File: rtl/mips_mem_align.sv
// Combinational address decode: word index, range/alignment/size errors,
// little-endian load lane extraction with extension, and store lane merge.
module mips_mem_align
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_BASE,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic [31:0]                    addr_i,
    input  logic [1:0]                     size_i,
    input  logic                           signed_i,
    input  logic [31:0]                    wdata_i,
    input  logic [31:0]                    word_i,
    output logic [$clog2(DEPTH_WORDS)-1:0] index_o,
    output logic                           error_o,
    output logic [31:0]                    rdata_o,
    output logic [31:0]                    merged_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // 33-bit offset so an address below the base shows up as a set borrow bit.
    logic [32:0] off;
    logic        out_of_range;
    logic        misaligned;
    logic        illegal;
    logic [31:0] shifted;
    logic [31:0] lane_dat;
    logic [31:0] load_dat;
    logic [3:0]  be;

    assign off          = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign out_of_range = off[32] || (off[31:2] >= 30'(DEPTH_WORDS));
    assign index_o      = off[AW+1:2];
    assign shifted      = word_i >> {off[1:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        be         = 4'b0000;
        lane_dat   = wdata_i;
        load_dat   = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be       = 4'b0001 << off[1:0];
                lane_dat = {4{wdata_i[7:0]}};
                load_dat = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                misaligned = off[0];
                be         = off[1] ? 4'b1100 : 4'b0011;
                lane_dat   = {2{wdata_i[15:0]}};
                load_dat   = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                misaligned = (off[1:0] != 2'b00);
                be         = 4'b1111;
                load_dat   = word_i;
            end
            default: illegal = 1'b1;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged_o[8*b +: 8] = be[b] ? lane_dat[8*b +: 8] : word_i[8*b +: 8];
        end
    end

    assign error_o = illegal || misaligned || out_of_range;
    assign rdata_o = error_o ? 32'h0 : load_dat;

endmodule

// File: rtl/mips_mem_port.sv
// Multi-cycle word-addressed memory with one outstanding valid/ready request
// and a one-cycle registered response after LATENCY cycles.
module mips_mem_port
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          live;
    logic          cur_write;
    logic [AW-1:0] idx;
    logic          al_error;
    logic [31:0]   al_rdata;
    logic [31:0]   al_merged;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the commit edge is the accept edge, so decode the live inputs.
    assign live      = (state_q == IDLE);
    assign cur_write = live ? req_write : write_q;

    mips_mem_align #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_align (
        .addr_i  (live ? req_addr   : addr_q),
        .size_i  (live ? req_size   : size_q),
        .signed_i(live ? req_signed : signed_q),
        .wdata_i (live ? req_wdata  : wdata_q),
        .word_i  (mem_q[idx]),
        .index_o (idx),
        .error_o (al_error),
        .rdata_o (al_rdata),
        .merged_o(al_merged)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // Leave when the count reaches zero so the response lands LATENCY cycles after accept.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= cur_write ? 32'h0 : al_rdata;
                error_q <= al_error;
            end
        end
    end

    // Array has no reset; contents survive it.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && cur_write && !al_error) begin
            mem_q[idx] <= al_merged;
        end
    end

endmodule

// File: tb/tb_mips_mem_port.sv
// Directed bench: four instances (latency 1/3/4 data, latency 2 text) driven one at a time.
module tb_mips_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_error;
    logic [31:0] rsp_rdata [4];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mips_mem_port #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

    mips_mem_port #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

    mips_mem_port #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

    mips_mem_port #(.BASE_ADDR(32'h00400000), .DEPTH_WORDS(16), .LATENCY(2)) u_txt (
        .clock(clock), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_error(rsp_error[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance k; checks ready, latency, busy ready, data and error.
    task automatic xact(input int k, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int lat,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        @(negedge clock);
        req_write  = wr;
        req_addr   = a;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
        req_valid[k] = 1'b1;
        chk({tag, ".ready"}, 32'(req_ready[k]), 32'd1);
        @(posedge clock);
        #1;
        req_valid[k] = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'b11;
        req_wdata  = 32'h0;
        req_write  = ~wr;
        req_signed = ~sg;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (rsp_valid[k]) begin
                n = i;
                break;
            end
            chk({tag, ".busy"}, 32'(req_ready[k]), 32'd0);
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".rdata"}, rsp_rdata[k], exp_d);
        chk({tag, ".err"}, 32'(rsp_error[k]), 32'(exp_e));
    endtask

    initial begin
        int pulses;
        int acc;
        int pcyc[$];

        reset      = 1'b1;
        req_valid  = 4'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
        @(posedge clock);
        @(negedge clock);
        chk("rst.ready", 32'(req_ready), 32'hf);
        chk("rst.valid", 32'(rsp_valid), 32'h0);
        chk("rst.err", 32'(rsp_error), 32'h0);
        for (int k = 0; k < 4; k++) chk("rst.rdata", rsp_rdata[k], 32'h0);
        reset = 1'b0;

        // Latency 1 store/load
        xact(0, 1, 32'h10010004, 2'b10, 0, 32'hdeadbeef, 1, 32'h0, 0, "l1.sw");
        xact(0, 0, 32'h10010004, 2'b10, 0, 32'h0, 1, 32'hdeadbeef, 0, "l1.lw");

        // Latency 3 sub-word accesses
        xact(1, 1, 32'h10010000, 2'b10, 0, 32'h807060f0, 3, 32'h0, 0, "l3.sw");
        xact(1, 0, 32'h10010000, 2'b00, 1, 32'h0, 3, 32'hfffffff0, 0, "l3.lb");
        xact(1, 0, 32'h10010000, 2'b00, 0, 32'h0, 3, 32'h000000f0, 0, "l3.lbu");
        xact(1, 0, 32'h10010002, 2'b01, 1, 32'h0, 3, 32'hffff8070, 0, "l3.lh");
        xact(1, 0, 32'h10010002, 2'b01, 0, 32'h0, 3, 32'h00008070, 0, "l3.lhu");
        xact(1, 1, 32'h10010001, 2'b00, 0, 32'hffffff11, 3, 32'h0, 0, "l3.sb");
        xact(1, 0, 32'h10010000, 2'b10, 0, 32'h0, 3, 32'h807011f0, 0, "l3.lw_sb");

        // Error cases; top word seeded so wrap-around writes would be visible
        xact(1, 1, 32'h10010ffc, 2'b10, 0, 32'h00000000, 3, 32'h0, 0, "l3.sw_top");
        xact(1, 0, 32'h10010002, 2'b10, 0, 32'h0, 3, 32'h0, 1, "err.lw_mis");
        xact(1, 0, 32'h10010001, 2'b01, 1, 32'h0, 3, 32'h0, 1, "err.lh_mis");
        xact(1, 1, 32'h10010002, 2'b10, 0, 32'hbad0bad0, 3, 32'h0, 1, "err.sw_mis");
        xact(1, 1, 32'h1000fffc, 2'b10, 0, 32'hbad0bad0, 3, 32'h0, 1, "err.sw_under");
        xact(1, 1, 32'h10011000, 2'b10, 0, 32'hbad0bad0, 3, 32'h0, 1, "err.sw_over");
        xact(1, 1, 32'h10010000, 2'b11, 0, 32'hbad0bad0, 3, 32'h0, 1, "err.size11");
        xact(1, 0, 32'h10010000, 2'b10, 0, 32'h0, 3, 32'h807011f0, 0, "err.word0");
        xact(1, 0, 32'h10010ffc, 2'b10, 0, 32'h0, 3, 32'h00000000, 0, "err.wordtop");

        // Reset mid-transaction drops the store and the response
        xact(2, 1, 32'h10010008, 2'b10, 0, 32'hcafef00d, 4, 32'h0, 0, "l4.pre");
        @(negedge clock);
        req_write = 1'b1;
        req_addr  = 32'h10010008;
        req_size  = 2'b10;
        req_wdata = 32'h12345678;
        req_valid[2] = 1'b1;
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        pulses = 0;
        @(negedge clock);
        if (rsp_valid[2]) pulses++;
        reset = 1'b1;
        @(negedge clock);
        if (rsp_valid[2]) pulses++;
        reset = 1'b0;
        chk("rst4.ready", 32'(req_ready[2]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rsp_valid[2]) pulses++;
        end
        chk("rst4.pulses", 32'(pulses), 32'd0);
        xact(2, 0, 32'h10010008, 2'b10, 0, 32'h0, 4, 32'hcafef00d, 0, "rst4.lw");

        // Text segment instance
        xact(3, 1, 32'h00400000, 2'b10, 0, 32'h24090064, 2, 32'h0, 0, "txt.sw0");
        xact(3, 1, 32'h00400004, 2'b10, 0, 32'h240a00c8, 2, 32'h0, 0, "txt.sw1");
        xact(3, 1, 32'h00400008, 2'b10, 0, 32'h012a5820, 2, 32'h0, 0, "txt.sw2");
        xact(3, 0, 32'h00400000, 2'b10, 0, 32'h0, 2, 32'h24090064, 0, "txt.lw0");
        xact(3, 0, 32'h00400004, 2'b10, 0, 32'h0, 2, 32'h240a00c8, 0, "txt.lw1");
        xact(3, 0, 32'h00400008, 2'b10, 0, 32'h0, 2, 32'h012a5820, 0, "txt.lw2");
        xact(3, 0, 32'h00400040, 2'b10, 0, 32'h0, 2, 32'h0, 1, "txt.lw_oor");

        // Back-to-back loads with req_valid held high
        @(negedge clock);
        req_write  = 1'b0;
        req_addr   = 32'h00400004;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_valid[3] = 1'b1;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clock);
            if (rsp_valid[3]) pcyc.push_back(c);
            if (acc == 5) req_valid[3] = 1'b0;
            if (req_valid[3] && req_ready[3]) acc++;
        end
        chk("proto.pulses", 32'(pcyc.size()), 32'd5);
        for (int i = 1; i < pcyc.size(); i++) chk("proto.gap", 32'(pcyc[i] - pcyc[i-1]), 32'd3);
        chk("proto.rdata", rsp_rdata[3], 32'h240a00c8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
